// File: rtl/io_bus_decoder_ws.sv
// Multi-window 68k IO address decoder with per-channel wait states and Dtack/Berr generation.
// Optional macro BERR_TIMEOUT_EN enables the unclaimed-access bus-error timeout.
module io_bus_decoder_ws #(
    parameter int                        NUM_CH   = 4,
    parameter int                        WIN_BITS = 4,
    parameter logic [16*NUM_CH-1:0]      CH_BASE  = {16'h8030, 16'h8020, 16'h8010, 16'h8000},
    parameter int                        WAIT_W   = 4,
    parameter logic [WAIT_W*NUM_CH-1:0]  CH_WAIT  = {4'd3, 4'd1, 4'd0, 4'd2},
    parameter int                        TIMEOUT  = 255
) (
    input  logic              Clk,
    input  logic              Reset_L,
    input  logic [31:0]       Address,
    input  logic              IO_Select_H,
    input  logic              AS_L,
    output logic [NUM_CH-1:0] Enable_H,
    output logic              Dtack_L,
    output logic              Berr_L,
    output logic              Busy_H
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_NOMATCH,
        S_BERR
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   enable_q, enable_d;
    logic                dtack_q, dtack_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;

    logic                hit;
    logic [NUM_CH-1:0]   hit_onehot;
    logic [WAIT_W-1:0]   hit_wait;

    // Only the IO-region offset above the window granule takes part in decoding.
    logic unused_addr;
    assign unused_addr = ^{Address[31:16], Address[WIN_BITS-1:0]};

    // Scanning from the top down lets the lowest matching index overwrite the others.
    always_comb begin
        hit        = 1'b0;
        hit_onehot = '0;
        hit_wait   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (IO_Select_H &&
                Address[15:WIN_BITS] == CH_BASE[16*i + WIN_BITS +: 16 - WIN_BITS]) begin
                hit           = 1'b1;
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_wait      = CH_WAIT[WAIT_W*i +: WAIT_W];
            end
        end
    end

`ifdef BERR_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic        berr_q, berr_d;
    logic [15:0] tcnt_q, tcnt_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        enable_d = enable_q;
        dtack_d  = dtack_q;
        cnt_d    = cnt_q;
`ifdef BERR_TIMEOUT_EN
        berr_d   = berr_q;
        tcnt_d   = tcnt_q;
`endif
        case (state_q)
            S_SYNC: begin
                if (AS_L) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!AS_L && IO_Select_H) begin
                    if (hit) begin
                        enable_d = hit_onehot;
                        cnt_d    = hit_wait;
                        state_d  = S_WAIT;
                    end else begin
`ifdef BERR_TIMEOUT_EN
                        tcnt_d   = '0;
`endif
                        state_d  = S_NOMATCH;
                    end
                end
            end
            S_WAIT: begin
                if (AS_L) begin
                    enable_d = '0;
                    state_d  = S_IDLE;
                end else if (cnt_q == '0) begin
                    dtack_d  = 1'b0;
                    state_d  = S_ACK;
                end else begin
                    cnt_d    = cnt_q - WAIT_W'(1);
                end
            end
            S_ACK: begin
                if (AS_L) begin
                    enable_d = '0;
                    dtack_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_NOMATCH: begin
                if (AS_L) begin
                    state_d = S_IDLE;
                end
`ifdef BERR_TIMEOUT_EN
                else begin
                    tcnt_d = tcnt_q + 16'd1;
                    if (tcnt_q == TMO_LAST) begin
                        berr_d  = 1'b0;
                        state_d = S_BERR;
                    end
                end
`endif
            end
            S_BERR: begin
                if (AS_L) begin
`ifdef BERR_TIMEOUT_EN
                    berr_d  = 1'b1;
`endif
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_SYNC;
                enable_d = '0;
                dtack_d  = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q  <= S_SYNC;
            enable_q <= '0;
            dtack_q  <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            dtack_q  <= dtack_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef BERR_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            berr_q <= 1'b1;
            tcnt_q <= '0;
        end else begin
            berr_q <= berr_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign Berr_L = berr_q;
`else
    assign Berr_L = 1'b1;
`endif

    assign Enable_H = enable_q;
    assign Dtack_L  = dtack_q;
    assign Busy_H   = (state_q != S_IDLE);

endmodule

// File: tb/tb_io_bus_decoder_ws.sv
// Directed self-checking bench for io_bus_decoder_ws with default parameters.
// Observed vector is {Enable_H[3:0], Dtack_L, Berr_L, Busy_H}.
module tb_io_bus_decoder_ws;

    logic        Clk;
    logic        Reset_L;
    logic [31:0] Address;
    logic        IO_Select_H;
    logic        AS_L;
    logic [3:0]  Enable_H;
    logic        Dtack_L;
    logic        Berr_L;
    logic        Busy_H;

    int total = 0;
    int bad   = 0;

    localparam int TIMEOUT = 255;

    io_bus_decoder_ws dut (
        .Clk         (Clk),
        .Reset_L     (Reset_L),
        .Address     (Address),
        .IO_Select_H (IO_Select_H),
        .AS_L        (AS_L),
        .Enable_H    (Enable_H),
        .Dtack_L     (Dtack_L),
        .Berr_L      (Berr_L),
        .Busy_H      (Busy_H)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        Reset_L     = 1'b0;
        AS_L        = 1'b0;
        IO_Select_H = 1'b1;
        Address     = 32'h0040_8024;
        tick();
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0000_111) begin
            bad++;
            $display("FAIL reset_values: got %b want %b", obs, 7'b0000_111);
        end
        // Release mid-cycle with a decodable address: nothing may be decoded.
        Reset_L = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
            total++;
            if (obs !== 7'b0000_111) begin
                bad++;
                $display("FAIL sync_hold[%0d]: got %b want %b", k, obs, 7'b0000_111);
            end
        end
        AS_L = 1'b1;
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0000_110) begin
            bad++;
            $display("FAIL sync_exit: got %b want %b", obs, 7'b0000_110);
        end
    endtask

    // Strobe edge is the first tick; Dtack_L falls wait_n+1 edges later.
    task automatic test_access(input logic [31:0] addr, input logic [3:0] exp_en,
                               input int wait_n, input string name);
        logic [6:0] obs;
        logic [6:0] exp;
        Address     = addr;
        IO_Select_H = 1'b1;
        AS_L        = 1'b0;
        for (int k = 0; k <= wait_n + 2; k++) begin
            tick();
            exp = {exp_en, (k >= wait_n + 1) ? 1'b0 : 1'b1, 1'b1, 1'b1};
            obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL %s edge n+%0d: got %b want %b", name, k, obs, exp);
            end
        end
        AS_L = 1'b1;
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0000_110) begin
            bad++;
            $display("FAIL %s release: got %b want %b", name, obs, 7'b0000_110);
        end
    endtask

    task automatic test_back_to_back();
        test_access(32'h0040_801F, 4'b0010, 0, "b2b_ch1");
        test_access(32'h0040_803C, 4'b1000, 3, "b2b_ch3");
    endtask

    task automatic test_io_select_low();
        logic [6:0] obs;
        Address     = 32'h0040_8000;
        IO_Select_H = 1'b0;
        AS_L        = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
            total++;
            if (obs !== 7'b0000_110) begin
                bad++;
                $display("FAIL io_select_low[%0d]: got %b want %b", k, obs, 7'b0000_110);
            end
        end
        AS_L        = 1'b1;
        IO_Select_H = 1'b1;
        tick();
    endtask

    task automatic test_unclaimed_short(input logic [31:0] addr, input string name);
        logic [6:0] obs;
        Address = addr;
        AS_L    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
            total++;
            if (obs !== 7'b0000_111) begin
                bad++;
                $display("FAIL %s[%0d]: got %b want %b", name, k, obs, 7'b0000_111);
            end
        end
        AS_L = 1'b1;
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0000_110) begin
            bad++;
            $display("FAIL %s release: got %b want %b", name, obs, 7'b0000_110);
        end
    endtask

    task automatic test_timeout();
        logic [6:0] obs;
        logic [6:0] exp;
        logic       exp_berr;
        Address = 32'h0040_9000;
        AS_L    = 1'b0;
        for (int k = 1; k <= TIMEOUT + 20; k++) begin
            tick();
`ifdef BERR_TIMEOUT_EN
            exp_berr = (k >= TIMEOUT + 1) ? 1'b0 : 1'b1;
`else
            exp_berr = 1'b1;
`endif
            exp = {4'b0000, 1'b1, exp_berr, 1'b1};
            obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL timeout tick %0d: got %b want %b", k, obs, exp);
            end
        end
        AS_L = 1'b1;
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0000_110) begin
            bad++;
            $display("FAIL timeout release: got %b want %b", obs, 7'b0000_110);
        end
    endtask

    task automatic test_abort();
        logic [6:0] obs;
        Address = 32'h0040_8030;
        AS_L    = 1'b0;
        tick();
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b1000_111) begin
            bad++;
            $display("FAIL abort_wait: got %b want %b", obs, 7'b1000_111);
        end
        AS_L = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
            total++;
            if (obs !== 7'b0000_110) begin
                bad++;
                $display("FAIL abort_after[%0d]: got %b want %b", k, obs, 7'b0000_110);
            end
        end
    endtask

    task automatic test_reset_in_ack();
        logic [6:0] obs;
        Address = 32'h0040_8010;
        AS_L    = 1'b0;
        tick();
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0010_011) begin
            bad++;
            $display("FAIL rst_ack_pre: got %b want %b", obs, 7'b0010_011);
        end
        Reset_L = 1'b0;
        #1;
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0000_111) begin
            bad++;
            $display("FAIL rst_ack_async: got %b want %b", obs, 7'b0000_111);
        end
        #2;
        Reset_L = 1'b1;
        tick();
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0000_111) begin
            bad++;
            $display("FAIL rst_ack_sync: got %b want %b", obs, 7'b0000_111);
        end
        AS_L = 1'b1;
        tick();
        obs = {Enable_H, Dtack_L, Berr_L, Busy_H};
        total++;
        if (obs !== 7'b0000_110) begin
            bad++;
            $display("FAIL rst_ack_idle: got %b want %b", obs, 7'b0000_110);
        end
    endtask

    initial begin
        test_reset();
        test_access(32'h0040_8024, 4'b0100, 1, "ch2_wait1");
        test_access(32'h0040_8005, 4'b0001, 2, "ch0_wait2");
        test_back_to_back();
        test_io_select_low();
        test_unclaimed_short(32'h0040_8040, "above_ch3");
        test_unclaimed_short(32'h0040_7FF0, "below_ch0");
        test_timeout();
        test_abort();
        test_reset_in_ack();
        test_access(32'h0040_802F, 4'b0100, 1, "ch2_after_reset");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
